fp_div_unit: RTL and testbench



---
 rtl/fp_div_pkg.sv | 28 ++
 rtl/fp_div_special.sv | 50 +++++
 rtl/fp_mul.sv | 52 +++++
 rtl/fp_recip.sv | 54 +++++
 rtl/fp_div_unit.sv | 127 ++++++++++++
 tb/tb_fp_div_unit.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divider.
// Holds the FSM state and special-case class enums, plus IEEE-754 field constants.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECIP,
        MUL,
        DONE
    } div_state_e;

    typedef enum logic [2:0] {
        NORMAL,
        NAN_OUT,
        INF_DZ,
        INF_OUT,
        ZERO_OUT
    } special_class_e;

    localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
    localparam logic [7:0]  FP_EXP_ZERO = 8'h00;

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

endpackage

// File: rtl/fp_div_special.sv
// Combinational operand classifier for A / B.
// Produces the special-case class, its fixed IEEE result and the divide-by-zero flag.
module fp_div_special
    import fp_div_pkg::*;
(
    input  logic [31:0]    a,
    input  logic [31:0]    b,
    output special_class_e cls,
    output logic [31:0]    spec_result,
    output logic           spec_dz
);

    logic a_zero;
    logic a_inf;
    logic a_nan;
    logic b_zero;
    logic b_inf;
    logic b_nan;
    logic sign;

    // Exponent 0 covers denormals too: they are flushed to zero.
    assign a_zero = (fp_exp(a) == FP_EXP_ZERO);
    assign a_inf  = (fp_exp(a) == FP_EXP_MAX) && (a[22:0] == 23'd0);
    assign a_nan  = (fp_exp(a) == FP_EXP_MAX) && (a[22:0] != 23'd0);
    assign b_zero = (fp_exp(b) == FP_EXP_ZERO);
    assign b_inf  = (fp_exp(b) == FP_EXP_MAX) && (b[22:0] == 23'd0);
    assign b_nan  = (fp_exp(b) == FP_EXP_MAX) && (b[22:0] != 23'd0);
    assign sign   = a[31] ^ b[31];

    always_comb begin
        cls         = NORMAL;
        spec_result = 32'd0;
        spec_dz     = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            cls         = NAN_OUT;
            spec_result = FP_QNAN;
        end else if (b_zero) begin
            cls         = INF_DZ;
            spec_result = {sign, FP_EXP_MAX, 23'd0};
            spec_dz     = 1'b1;
        end else if (a_inf) begin
            cls         = INF_OUT;
            spec_result = {sign, FP_EXP_MAX, 23'd0};
        end else if (a_zero || b_inf) begin
            cls         = ZERO_OUT;
            spec_result = {sign, 31'd0};
        end
    end

endmodule

// File: rtl/fp_mul.sv
// Combinational single-precision multiplier, round-to-nearest, flush-to-zero.
// Saturates to infinity on exponent overflow and to signed zero on underflow.
module fp_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    logic [47:0]       prod;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic              sign;
    logic              zero_in;
    logic signed [9:0] exp_s;

    function automatic logic [24:0] round_mant(input logic [47:0] pr);
        logic [24:0] m;
        logic        r;
        if (pr[47]) begin
            m = 25'(pr >> 24);
            r = pr[23];
        end else begin
            m = 25'(pr >> 23);
            r = pr[22];
        end
        return m + {24'd0, r};
    endfunction

    function automatic logic [31:0] sat_pack(input logic s, input logic signed [9:0] e,
                                             input logic [22:0] f, input logic z);
        if (z || (e < 10'sd1)) begin
            return {s, 31'd0};
        end
        if (e > 10'sd254) begin
            return {s, 8'hFF, 23'd0};
        end
        return {s, e[7:0], f};
    endfunction

    always_comb begin
        sign    = a[31] ^ b[31];
        zero_in = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
        prod    = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        mant_r  = round_mant(prod);
        // Rounding carry-out renormalises by one more binade.
        frac    = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        exp_s   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
                + $signed({9'd0, prod[47]}) + $signed({9'd0, mant_r[24]});
        p       = sat_pack(sign, exp_s, frac, zero_in);
    end

endmodule

// File: rtl/fp_recip.sv
// Combinational Newton-Raphson reciprocal 1/B for normal single-precision B.
// Linear seed plus three iterations in Q2.32, rounded to nearest on packing.
module fp_recip (
    input  logic [31:0] b,
    output logic [31:0] recip
);

    // Seed x0 = 48/17 - 32/17 * d, both constants in Q2.32.
    localparam logic [33:0] NR_C1  = 34'd12126966483;
    localparam logic [33:0] NR_C2  = 34'd8084644322;
    localparam logic [33:0] NR_TWO = 34'h2_0000_0000;
    localparam logic [33:0] NR_RND = 34'd256;

    logic [31:0]       d_fix;
    logic [33:0]       x0;
    logic [33:0]       x1;
    logic [33:0]       x2;
    logic [33:0]       x3;
    logic [33:0]       xr;
    logic signed [9:0] exp_s;

    function automatic logic [33:0] nr_seed(input logic [31:0] d);
        logic [65:0] c2d;
        c2d = {32'd0, NR_C2} * {34'd0, d};
        return NR_C1 - 34'(c2d >> 32);
    endfunction

    function automatic logic [33:0] nr_step(input logic [31:0] d, input logic [33:0] x);
        logic [65:0] dx_full;
        logic [33:0] t;
        logic [67:0] xt_full;
        dx_full = {34'd0, d} * {32'd0, x};
        t       = NR_TWO - 34'(dx_full >> 32);
        xt_full = {34'd0, x} * {34'd0, t};
        return 34'(xt_full >> 32);
    endfunction

    always_comb begin
        // Mantissa 1.f scaled by 1/2 so d lies in [0.5, 1) and 1/d in (1, 2].
        d_fix = {1'b1, b[22:0], 8'd0};
        x0    = nr_seed(d_fix);
        x1    = nr_step(d_fix, x0);
        x2    = nr_step(d_fix, x1);
        x3    = nr_step(d_fix, x2);
        xr    = x3 + NR_RND;
        exp_s = (xr[33] ? 10'sd254 : 10'sd253) - $signed({2'b00, b[30:23]});
        if (exp_s < 10'sd1) begin
            recip = {b[31], 31'd0};
        end else begin
            recip = {b[31], exp_s[7:0], xr[33] ? 23'd0 : 23'(xr >> 9)};
        end
    end

endmodule

// File: rtl/fp_div_unit.sv
// Sequential IEEE-754 single divider A / B = A * (1/B) with valid/ready handshake.
// Reciprocal and multiplier paths are given multicycle hold slots before capture.
module fp_div_unit
    import fp_div_pkg::*;
#(
    parameter int RECIP_WAIT = 2,
    parameter int MUL_WAIT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        div_by_zero,
    output logic        busy
);

    localparam int WAIT_MAX = (RECIP_WAIT > MUL_WAIT) ? RECIP_WAIT : MUL_WAIT;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] RECIP_LAST = CNT_W'(RECIP_WAIT - 1);
    localparam logic [CNT_W-1:0] MUL_LAST   = CNT_W'(MUL_WAIT - 1);

    div_state_e     state;
    div_state_e     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [31:0]    recip_q;
    logic [31:0]    recip_w;
    logic [31:0]    prod_w;
    special_class_e cls;
    logic [31:0]    spec_result;
    logic           spec_dz;
    logic           accept;
    logic           recip_last;
    logic           mul_last;

    fp_div_special u_special (
        .a           (a),
        .b           (b),
        .cls         (cls),
        .spec_result (spec_result),
        .spec_dz     (spec_dz)
    );

    // Datapaths see only the captured operands, so a/b may change after accept.
    fp_recip u_recip (
        .b     (b_q),
        .recip (recip_w)
    );

    fp_mul u_mul (
        .a (a_q),
        .b (recip_q),
        .p (prod_w)
    );

    assign accept     = in_valid && in_ready;
    assign recip_last = (state == RECIP) && (cnt == RECIP_LAST);
    assign mul_last   = (state == MUL) && (cnt == MUL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = (cls == NORMAL) ? RECIP : DONE;
            RECIP:   if (recip_last) state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // Hold-slot counter: runs only inside RECIP and MUL, restarts for each.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state == RECIP && !recip_last) || (state == MUL && !mul_last)) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            recip_q     <= 32'd0;
            result      <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                a_q         <= a;
                b_q         <= b;
                div_by_zero <= spec_dz;
                if (cls != NORMAL) begin
                    result <= spec_result;
                end
            end
            if (recip_last) begin
                recip_q <= recip_w;
            end
            if (mul_last) begin
                result <= prod_w;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_unit.sv
// Directed self-checking bench for fp_div_unit: default timing instance plus a 4/2 sweep instance.
module tb_fp_div_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero;
    logic        busy;

    logic        in_valid2;
    logic        in_ready2;
    logic [31:0] a2;
    logic [31:0] b2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] result2;
    logic        div_by_zero2;
    logic        busy2;

    int n_checks;
    int n_fail;

    fp_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    fp_div_unit #(.RECIP_WAIT(4), .MUL_WAIT(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .a           (a2),
        .b           (b2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .result      (result2),
        .div_by_zero (div_by_zero2),
        .busy        (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned ulp_dist(input logic [31:0] x, input logic [31:0] y);
        if (x[31] != y[31]) return 32'hFFFF_FFFF;
        return (x > y) ? (x - y) : (y - x);
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", result); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
        n_checks++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_dut2: in_ready %b out_valid %b want 1 0", in_ready2, out_valid2); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal();
        logic [31:0] va [3] = '{32'h40C00000, 32'hC1000000, 32'h3F800000};
        logic [31:0] vb [3] = '{32'h40400000, 32'h40000000, 32'h40400000};
        logic [31:0] ve [3] = '{32'h40000000, 32'hC0800000, 32'h3EAAAAAB};
        int   lat;
        logic busy_ok;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i];
            @(posedge clk); #1;
            in_valid = 1'b0; a = $urandom; b = $urandom;
            lat = 0; busy_ok = 1'b1;
            while (out_valid !== 1'b1 && lat < 20) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
            n_checks++; if (lat != 3) begin n_fail++; $display("FAIL norm_latency[%0d]: got %0d want 3", i, lat); end
            n_checks++; if (ulp_dist(result, ve[i]) > 2) begin n_fail++; $display("FAIL norm_result[%0d]: got %h want %h +-2ulp", i, result, ve[i]); end
            n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL norm_dz[%0d]: got %b want 0", i, div_by_zero); end
            n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL norm_busy[%0d]: busy dropped before out_valid, want 1", i); end
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL norm_release[%0d]: out_valid %b in_ready %b want 0 1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_special();
        logic [31:0] va [8] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800001,
                                32'h7F800000, 32'hBF800000, 32'h40400000, 32'h00000000};
        logic [31:0] vb [8] = '{32'h00000000, 32'h00000000, 32'hC0000000, 32'h3F800000,
                                32'h7F800000, 32'h80000000, 32'hFF800000, 32'h40000000};
        logic [31:0] ve [8] = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
                                32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000000};
        logic        vz [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL spec_latency[%0d]: out_valid %b want 1 one edge after accept", i, out_valid); end
            n_checks++; if (result !== ve[i]) begin n_fail++; $display("FAIL spec_result[%0d]: got %h want %h", i, result, ve[i]); end
            n_checks++; if (div_by_zero !== vz[i]) begin n_fail++; $display("FAIL spec_dz[%0d]: got %b want %b", i, div_by_zero, vz[i]); end
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL spec_release[%0d]: out_valid %b in_ready %b want 0 1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [31:0] held;
        out_ready = 1'b0;
        in_valid = 1'b1; a = 32'h40C00000; b = 32'h40400000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL bp_latency: got %0d want 3", lat); end
        held = result;
        n_checks++; if (ulp_dist(held, 32'h40000000) > 2) begin n_fail++; $display("FAIL bp_result: got %h want 40000000 +-2ulp", held); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; a = 32'h3F800000; b = 32'h00000000;
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid); end
            n_checks++; if (result !== held || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %h dz %b want %h dz 0", c, result, div_by_zero, held); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || result !== held) begin n_fail++; $display("FAIL bp_ignored: out_valid %b result %h want 0 %h", out_valid, result, held); end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 32'h40C00000; b = 32'h40400000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pre: busy %b out_valid %b want 1 0", busy, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: in_ready %b busy %b want 1 0", in_ready, busy); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_result: got %h want 00000000", result); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_partial: out_valid %b want 0", out_valid); end
        in_valid = 1'b1; a = 32'h40C00000; b = 32'h40400000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 3", lat); end
        n_checks++; if (ulp_dist(result, 32'h40000000) > 2) begin n_fail++; $display("FAIL rst_after_result: got %h want 40000000 +-2ulp", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_param_sweep();
        logic [31:0] va [2] = '{32'h40C00000, 32'hC1000000};
        logic [31:0] vb [2] = '{32'h40400000, 32'h40000000};
        logic [31:0] ve [2] = '{32'h40000000, 32'hC0800000};
        int lat;
        out_ready2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL sweep_idle[%0d]: in_ready2 %b want 1", i, in_ready2); end
            in_valid2 = 1'b1; a2 = va[i]; b2 = vb[i];
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            lat = 0;
            while (out_valid2 !== 1'b1 && lat < 30) begin
                a2 = $urandom; b2 = $urandom;
                @(posedge clk); #1;
                lat++;
            end
            n_checks++; if (lat != 6) begin n_fail++; $display("FAIL sweep_latency[%0d]: got %0d want 6", i, lat); end
            n_checks++; if (ulp_dist(result2, ve[i]) > 2) begin n_fail++; $display("FAIL sweep_result[%0d]: got %h want %h +-2ulp", i, result2, ve[i]); end
            n_checks++; if (div_by_zero2 !== 1'b0) begin n_fail++; $display("FAIL sweep_dz[%0d]: got %b want 0", i, div_by_zero2); end
            @(posedge clk); #1;
            n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL sweep_release[%0d]: out_valid2 %b want 0", i, out_valid2); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = 32'h0;
        b          = 32'h0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        a2         = 32'h0;
        b2         = 32'h0;
        out_ready2 = 1'b0;

        test_reset();
        test_normal();
        test_special();
        test_backpressure();
        test_reset_mid();
        test_param_sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
